ifetch: RTL
===========

# ifetch

Instruction fetch unit: the read-side initiator for the synchronous instruction memory. It owns the fetch PC and drives word addresses into the memory, which returns data one cycle later. It buffers returned words in a 2-entry queue and hands them to decode over a valid/ready handshake. Decode or execute can redirect it to a new PC, which flushes all buffered and in-flight fetches.

## Interface
Parameters:
- `N`, default 5: instruction memory address width in words (2**N words).
- `RESET_PC`, default 32'h0000_0000: byte PC fetched first after reset.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `imem_addr`, output, N: word address to memory; always `fetch_pc[N+1:2]`.
- `imem_data`, input, 32: memory read data; it is the word at the `imem_addr` sampled on the previous edge.
- `inst`, output, 32: instruction at the head of the queue.
- `inst_pc`, output, 32: byte PC of `inst`.
- `inst_valid`, output, 1: queue non-empty.
- `inst_ready`, input, 1: decode accepts the head entry. A pop occurs when `inst_valid & inst_ready`.
- `redirect`, input, 1: load a new fetch PC.
- `redirect_pc`, input, 32: byte target PC.
- `fault`, output, 1: present only with `IFETCH_FAULT_EN`; see Configuration.

## Operation
State:
- `fetch_pc` (32).
- `inflight` (1) and `inflight_pc` (32).
- Queue of 2 entries {inst, pc} with `count` 0..2.

Issue:
- Issue occurs on an edge when `count - pop + inflight + 1 <= 2` and no redirect.
- On issue: `inflight<=1`, `inflight_pc<=fetch_pc`, `fetch_pc<=fetch_pc+4` (mod 2**32).
- Otherwise: `inflight<=0` and `fetch_pc` holds.

Return:
- If `inflight` is set at an edge, `{imem_data, inflight_pc}` is pushed into the queue.
- The issue rule guarantees the queue never overflows.

Pop:
- A pop removes the head entry.
- Push and pop can occur on the same edge. `count` then stays the same, and ordering is preserved (FIFO).

Redirect (highest priority):
- On an edge with `redirect=1`: `count<=0`, `inflight<=0`, `fetch_pc<={redirect_pc[31:2],2'b00}`.
- Any pop or push on that edge is discarded.
- No issue occurs on that edge.

Address range:
- Upper PC bits above N+1 are ignored by memory, so addresses wrap modulo 2**N words.
- `inst_pc` still reports the full 32-bit PC.

Reset:
- `fetch_pc<=RESET_PC`, `count<=0`, `inflight<=0`.
- Reset applies mid-operation at any edge and overrides redirect.

## Timing
Output values in reset: `inst_valid=0`, `inst=0`, `inst_pc=0`, `fault=0`, `imem_addr=RESET_PC[N+1:2]`.

Latency:
- First edge with `rst_n=1`: issue of `RESET_PC`.
- Next edge: push.
- `inst_valid=1` two edges after reset release.
- Redirect to valid is also 2 edges: redirect edge E, issue at E+1, push at E+2, valid after E+2.

Throughput:
- With `inst_ready` held high, 1 instruction per cycle, sustained.

Stall and release:
- With `inst_ready` low, the queue fills to 2 and issue stops. `fetch_pc` holds, so `imem_addr` is stable.
- When `inst_ready` rises, issue resumes on the same edge as the first pop.
- No bubbles beyond the 1-cycle memory latency: after a full stall, outputs continue back-to-back.

Queue outputs:
- `inst`/`inst_pc` are held stable while `inst_valid=1` and there is no pop.

## Configuration
`IFETCH_FAULT_EN` adds the `fault` port and misaligned/out-of-range detection.

With the macro defined:
- A redirect where `redirect_pc[1:0]!=0` or `redirect_pc >= 4*2**N` sets `fault<=1`.
- `fault` blocks all issue; `inst_valid` stays 0.
- `fault` clears only on a later valid redirect, or on reset.

Without the macro:
- No `fault` port.
- Low 2 bits are forced to zero.
- Upper bits wrap as in Operation.

## Test plan
- Reset release, `RESET_PC=0`, memory word i = i, `inst_ready=1` -> `inst_valid` rises 2 edges after release. `inst`/`inst_pc` then read 0/0, 1/4, 2/8, … on consecutive cycles.
- Stall: hold `inst_ready=0` for 5 cycles after the first valid -> `count=2`, `imem_addr` stable. After release, the instructions at PC 0, 4, 8 arrive back-to-back with no gap.
- Redirect to 0x40 on a cycle that has a pop and a push -> queue is flushed. No stale PC is ever presented. The next valid has `inst_pc=0x40` exactly 2 edges later.
- Redirect to 0x41 -> fetch resumes at 0x40 without the macro. With `IFETCH_FAULT_EN`: `fault=1`, `inst_valid` stays 0, then a redirect to 0x10 clears the fault.
- Wrap: `N=5`, redirect to 0x7C -> `inst_pc` values 0x7C, 0x80 with `imem_addr` 31, 0 (no macro). With the macro, 0x80 as a redirect target faults.
- Reset asserted mid-stream with a full queue and an in-flight fetch -> the next edge gives `inst_valid=0`. Fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch unit: owns the fetch PC, issues word reads to a 1-cycle synchronous imem,
// buffers returns in a 2-entry FIFO for decode. Optional IFETCH_FAULT_EN adds redirect fault checks.
module ifetch #(
    parameter int unsigned N        = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [N-1:0] imem_addr,
    input  logic [31:0]  imem_data,
    output logic [31:0]  inst,
    output logic [31:0]  inst_pc,
    output logic         inst_valid,
    input  logic         inst_ready,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc
`ifdef IFETCH_FAULT_EN
    ,
    output logic         fault
`endif
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] q_inst_q [2];
    logic [31:0] q_inst_d [2];
    logic [31:0] q_pc_q [2];
    logic [31:0] q_pc_d [2];
    logic        fault_q, fault_d;

    logic        pop, push, issue;
    logic        redirect_bad;

`ifdef IFETCH_FAULT_EN
    assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (|redirect_pc[31:N+2]);
    assign fault        = fault_q;
`else
    assign redirect_bad = 1'b0;
`endif

    assign inst_valid = (count_q != 2'd0);
    assign inst       = inst_valid ? q_inst_q[0] : 32'h0;
    assign inst_pc    = inst_valid ? q_pc_q[0] : 32'h0;
    assign imem_addr  = fetch_pc_q[N+1:2];

    assign pop  = inst_valid & inst_ready;
    assign push = inflight_q;
    // Only issue when the return slot is guaranteed to fit after this edge's pop.
    assign issue = !redirect && !fault_q &&
                   (({1'b0, count_q} + {2'b00, inflight_q} + 3'd1) <= (3'd2 + {2'b00, pop}));

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        q_inst_d      = q_inst_q;
        q_pc_d        = q_pc_q;
        fault_d       = fault_q;

        if (redirect) begin
            count_d    = 2'd0;
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            fault_d    = redirect_bad;
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end

            unique case ({push, pop})
                2'b11: begin
                    if (count_q == 2'd2) begin
                        q_inst_d[0] = q_inst_q[1];
                        q_pc_d[0]   = q_pc_q[1];
                        q_inst_d[1] = imem_data;
                        q_pc_d[1]   = inflight_pc_q;
                    end else begin
                        q_inst_d[0] = imem_data;
                        q_pc_d[0]   = inflight_pc_q;
                    end
                end
                2'b10: begin
                    q_inst_d[count_q[0]] = imem_data;
                    q_pc_d[count_q[0]]   = inflight_pc_q;
                    count_d              = count_q + 2'd1;
                end
                2'b01: begin
                    q_inst_d[0] = q_inst_q[1];
                    q_pc_d[0]   = q_pc_q[1];
                    count_d     = count_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            count_q       <= 2'd0;
            q_inst_q[0]   <= 32'h0;
            q_inst_q[1]   <= 32'h0;
            q_pc_q[0]     <= 32'h0;
            q_pc_q[1]     <= 32'h0;
            fault_q       <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            q_inst_q      <= q_inst_d;
            q_pc_q        <= q_pc_d;
            fault_q       <= fault_d;
        end
    end

endmodule
